hash_sequencer: RTL and testbench

HASH_SEQUENCER -- requirements
Module: hash_sequencer

---
 rtl/hash_sequencer.sv | 148 ++++++++++++++
 tb/tb_hash_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_sequencer.sv
// hash_sequencer: byte-serial control sequencer for a round-based hash datapath.
// Each accepted byte gets one load strobe and eight byte rounds; after the
// final byte, eight counter rounds run and the resulting R_h is captured as
// the digest, held until the consumer acknowledges it.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a message; all control outputs low
// INIT    | one-cycle start pulse to re-initialise the datapath
// LOAD    | msg_ready high; waiting for an upstream byte
// LATCH   | one-cycle validate_input with the new byte stable on B
// MROUND  | eight byte rounds, R_i = 0..7, switch_operation = 0
// CROUND  | eight counter rounds, R_i = 0..7, switch_operation = 1
// CAPTURE | all control low; digest loads R_h at the end of this cycle
// DONE    | digest_valid high until digest_ack

module hash_sequencer (
  input  logic        clock,
  input  logic        rstn,
  input  logic        msg_valid,
  input  logic [7:0]  msg_data,
  input  logic        msg_last,
  output logic        msg_ready,
  input  logic [31:0] R_h,
  output logic [7:0]  B,
  output logic        start,
  output logic        validate_input,
  output logic        switch_operation,
  output logic        validate_R_h,
  output logic [2:0]  R_i,
  output logic [31:0] digest,
  output logic        digest_valid,
  input  logic        digest_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    LOAD    = 3'd2,
    LATCH   = 3'd3,
    MROUND  = 3'd4,
    CROUND  = 3'd5,
    CAPTURE = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t state;
  logic   last_flag;

  // Sequencer: every output is registered and set on entry to the state
  // that owns it, so the outputs are a pure function of the current state.
  // R_i doubles as the round counter and is cleared on every round exit.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      last_flag        <= 1'b0;
      B                <= 8'h00;
      digest           <= 32'h0000_0000;
      msg_ready        <= 1'b0;
      start            <= 1'b0;
      validate_input   <= 1'b0;
      switch_operation <= 1'b0;
      validate_R_h     <= 1'b0;
      R_i              <= 3'd0;
      digest_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_valid) begin
            state <= INIT;
            start <= 1'b1;
          end
        end

        INIT: begin
          start     <= 1'b0;
          msg_ready <= 1'b1;
          state     <= LOAD;
        end

        LOAD: begin
          // msg_ready is high throughout LOAD, so msg_valid alone is the handshake
          if (msg_valid) begin
            B              <= msg_data;
            last_flag      <= msg_last;
            msg_ready      <= 1'b0;
            validate_input <= 1'b1;
            state          <= LATCH;
          end
        end

        LATCH: begin
          validate_input   <= 1'b0;
          validate_R_h     <= 1'b1;
          switch_operation <= 1'b0;
          R_i              <= 3'd0;
          state            <= MROUND;
        end

        MROUND: begin
          if (R_i == 3'd7) begin
            R_i <= 3'd0;
            if (last_flag) begin
              switch_operation <= 1'b1;
              state            <= CROUND;
            end else begin
              validate_R_h <= 1'b0;
              msg_ready    <= 1'b1;
              state        <= LOAD;
            end
          end else begin
            R_i <= R_i + 3'd1;
          end
        end

        CROUND: begin
          if (R_i == 3'd7) begin
            R_i              <= 3'd0;
            validate_R_h     <= 1'b0;
            switch_operation <= 1'b0;
            state            <= CAPTURE;
          end else begin
            R_i <= R_i + 3'd1;
          end
        end

        CAPTURE: begin
          digest       <= R_h;
          digest_valid <= 1'b1;
          last_flag    <= 1'b0;
          state        <= DONE;
        end

        DONE: begin
          if (digest_ack) begin
            digest_valid <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_sequencer.sv
// Directed bench for hash_sequencer: single-byte timing, multi-byte counts,
// upstream stall, held digest, and reset in the middle of a round.

module tb_hash_sequencer;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        msg_valid = 1'b0;
  logic [7:0]  msg_data = 8'h00;
  logic        msg_last = 1'b0;
  logic        msg_ready;
  logic [31:0] R_h = 32'h0;
  logic [7:0]  B;
  logic        start;
  logic        validate_input;
  logic        switch_operation;
  logic        validate_R_h;
  logic [2:0]  R_i;
  logic [31:0] digest;
  logic        digest_valid;
  logic        digest_ack = 1'b0;

  int total = 0;
  int bad = 0;

  int cnt_start = 0;
  int cnt_vi = 0;
  int cnt_m = 0;
  int cnt_c = 0;
  int cnt_ready = 0;

  hash_sequencer dut (
    .clock(clock),
    .rstn(rstn),
    .msg_valid(msg_valid),
    .msg_data(msg_data),
    .msg_last(msg_last),
    .msg_ready(msg_ready),
    .R_h(R_h),
    .B(B),
    .start(start),
    .validate_input(validate_input),
    .switch_operation(switch_operation),
    .validate_R_h(validate_R_h),
    .R_i(R_i),
    .digest(digest),
    .digest_valid(digest_valid),
    .digest_ack(digest_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle invariants plus event counters, sampled on the falling edge
  always @(negedge clock) begin
    chk("excl", 32'($countones({start, validate_input, validate_R_h}) <= 1), 32'd1);
    if (!validate_R_h) chk("ri_zero", 32'(R_i), 32'd0);
    if (start) cnt_start++;
    if (validate_input) cnt_vi++;
    if (validate_R_h && !switch_operation) cnt_m++;
    if (validate_R_h && switch_operation) cnt_c++;
    if (msg_ready) cnt_ready++;
  end

  // Reset for two cycles and release on a falling edge
  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
  endtask

  // which: 0 = msg_ready, 1 = digest_valid, 2 = byte round with R_i == 4
  task automatic wait_for(input int which, input string tag);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      case (which)
        0: hit = msg_ready;
        1: hit = digest_valid;
        default: hit = validate_R_h && !switch_operation && (R_i == 3'd4);
      endcase
      if (!hit) begin
        @(negedge clock);
        n++;
      end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  logic [8:0] exp_ctl;
  logic [8:0] got_ctl;
  int b_start, b_vi, b_m, b_c, b_ready;
  int first_start, first_vi;
  logic [7:0] bytes3 [3];

  initial begin
    bytes3[0] = 8'h01;
    bytes3[1] = 8'h02;
    bytes3[2] = 8'h03;

    // Reset state
    @(negedge clock);
    #1;
    chk("rst_ctl", 32'({start, msg_ready, validate_input, validate_R_h, switch_operation, R_i, digest_valid}), 32'd0);
    chk("rst_b", 32'(B), 32'h00);
    chk("rst_digest", digest, 32'h0);

    // Test 1: single byte 0xA5, cycle-exact timeline
    msg_valid = 1'b1;
    msg_data  = 8'hA5;
    msg_last  = 1'b1;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      exp_ctl = 9'd0;
      if (c == 1) exp_ctl[8] = 1'b1;
      if (c == 2) exp_ctl[7] = 1'b1;
      if (c == 3) exp_ctl[6] = 1'b1;
      if (c >= 4 && c <= 11) begin
        exp_ctl[5]   = 1'b1;
        exp_ctl[3:1] = 3'(c - 4);
      end
      if (c >= 12 && c <= 19) begin
        exp_ctl[5]   = 1'b1;
        exp_ctl[4]   = 1'b1;
        exp_ctl[3:1] = 3'(c - 12);
      end
      if (c >= 21) exp_ctl[0] = 1'b1;
      got_ctl = {start, msg_ready, validate_input, validate_R_h, switch_operation, R_i, digest_valid};
      chk($sformatf("t1_ctl_c%0d", c), 32'(got_ctl), 32'(exp_ctl));
      chk($sformatf("t1_b_c%0d", c), 32'(B), (c >= 3) ? 32'hA5 : 32'h0);
      chk($sformatf("t1_dig_c%0d", c), digest, (c >= 21) ? 32'h5A00_0014 : 32'h0);
      R_h = 32'h5A00_0000 | 32'(c);
      if (c == 3) msg_valid = 1'b0;
      @(negedge clock);
    end
    digest_ack = 1'b1;
    @(negedge clock);
    digest_ack = 1'b0;
    chk("t1_ack_dv", 32'(digest_valid), 32'd0);
    chk("t1_ack_dig", digest, 32'h5A00_0014);

    // Test 2: three bytes with msg_valid continuous
    R_h       = 32'h1234_5678;
    msg_valid = 1'b1;
    msg_data  = bytes3[0];
    msg_last  = 1'b0;
    do_reset();
    b_start = cnt_start; b_vi = cnt_vi; b_m = cnt_m; b_c = cnt_c; b_ready = cnt_ready;
    for (int i = 0; i < 3; i++) begin
      msg_data = bytes3[i];
      msg_last = (i == 2);
      wait_for(0, $sformatf("t2_ready%0d", i));
      @(posedge clock);
      #1;
    end
    msg_valid = 1'b0;
    wait_for(1, "t2_done");
    chk("t2_starts", 32'(cnt_start - b_start), 32'd1);
    chk("t2_vi", 32'(cnt_vi - b_vi), 32'd3);
    chk("t2_mround", 32'(cnt_m - b_m), 32'd24);
    chk("t2_cround", 32'(cnt_c - b_c), 32'd8);
    chk("t2_ready", 32'(cnt_ready - b_ready), 32'd3);
    chk("t2_b", 32'(B), 32'h03);
    chk("t2_digest", digest, 32'h1234_5678);
    digest_ack = 1'b1;
    @(negedge clock);
    digest_ack = 1'b0;
    chk("t2_ack_dv", 32'(digest_valid), 32'd0);

    // Test 3: upstream stall in LOAD
    R_h       = 32'hCAFE_0003;
    msg_valid = 1'b1;
    msg_data  = 8'h11;
    msg_last  = 1'b0;
    wait_for(0, "t3_ready0");
    @(posedge clock);
    #1;
    msg_valid = 1'b0;
    msg_data  = 8'h22;
    msg_last  = 1'b1;
    @(negedge clock);
    wait_for(0, "t3_ready1");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_hold%0d", k), 32'({msg_ready, validate_input, validate_R_h}), 32'b100);
      chk($sformatf("t3_b%0d", k), 32'(B), 32'h11);
      @(negedge clock);
    end
    msg_valid = 1'b1;
    @(negedge clock);
    chk("t3_resume_vi", 32'(validate_input), 32'd1);
    chk("t3_resume_b", 32'(B), 32'h22);
    msg_valid = 1'b0;

    // Test 4: digest held while ack withheld; msg_valid during DONE ignored
    wait_for(1, "t4_done");
    msg_valid = 1'b1;
    msg_data  = 8'h77;
    msg_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_dv%0d", k), 32'({digest_valid, msg_ready}), 32'b10);
      chk($sformatf("t4_dig%0d", k), digest, 32'hCAFE_0003);
      chk($sformatf("t4_b%0d", k), 32'(B), 32'h22);
      @(negedge clock);
    end
    digest_ack = 1'b1;
    @(negedge clock);
    digest_ack = 1'b0;
    chk("t4_idle", 32'({digest_valid, start}), 32'b00);
    chk("t4_keep", digest, 32'hCAFE_0003);
    @(negedge clock);
    chk("t4_init", 32'(start), 32'd1);

    // Test 5: reset during a byte round at R_i = 4
    wait_for(2, "t5_ri4");
    rstn = 1'b0;
    #1;
    chk("t5_rst_ctl", 32'({start, msg_ready, validate_input, validate_R_h, switch_operation, R_i, digest_valid}), 32'd0);
    chk("t5_rst_b", 32'(B), 32'h00);
    chk("t5_rst_dig", digest, 32'h0);
    @(negedge clock);
    rstn = 1'b1;
    first_start = -1;
    first_vi    = 99;
    for (int k = 0; k < 20; k++) begin
      if (start && first_start < 0) first_start = k;
      if (validate_input && first_vi == 99) first_vi = k;
      @(negedge clock);
    end
    chk("t5_start_seen", 32'(first_start >= 0), 32'd1);
    chk("t5_order", 32'(first_start < first_vi), 32'd1);
    msg_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
